// File: rtl/pong_score_ctrl.sv
// Pong game sequencer: serve delay, point scoring, win detection.
// Drives enable/reset pulses into the two external score counters.
module pong_score_ctrl #(
  parameter int WIN_SCORE   = 11,
  parameter int SERVE_DELAY = 60
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       FrameTick,
  input  logic       Start,
  input  logic       PointL,
  input  logic       PointR,
  input  logic [7:0] ScoreL,
  input  logic [7:0] ScoreR,
  output logic       EnL,
  output logic       EnR,
  output logic       CntRst,
  output logic       BallRun,
  output logic       ServeDir,
  output logic       GameOver,
  output logic       Winner,
  output logic [2:0] State
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    SCORE = 3'd3,
    CHECK = 3'd4,
    OVER  = 3'd5
  } state_t;

  localparam logic [7:0] WIN = 8'(WIN_SCORE);
  localparam logic [7:0] DLY = 8'(SERVE_DELAY);

  state_t     state_q, state_d;
  logic [7:0] delay_q, delay_d;
  logic       pend_q, pend_d;
  logic       start_q;
  logic       start_rise;
  logic       dir_d, win_d, crst_d;

  assign start_rise = Start & ~start_q;
  assign State      = state_q;

  // next-state, delay counter and held-output selection
  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    pend_d  = pend_q;
    dir_d   = ServeDir;
    win_d   = Winner;
    crst_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_d = SERVE;
          crst_d  = 1'b1;
          delay_d = DLY;
          dir_d   = 1'b1;
        end
      end
      SERVE: begin
        if (FrameTick) begin
          if (delay_q <= 8'd1) state_d = PLAY;
          else delay_d = delay_q - 8'd1;
        end
      end
      PLAY: begin
        if (PointL) begin
          state_d = SCORE;
          pend_d  = 1'b0;
        end else if (PointR) begin
          state_d = SCORE;
          pend_d  = 1'b1;
        end
      end
      SCORE: state_d = CHECK;
      CHECK: begin
        if (ScoreL >= WIN) begin
          state_d = OVER;
          win_d   = 1'b0;
        end else if (ScoreR >= WIN) begin
          state_d = OVER;
          win_d   = 1'b1;
        end else begin
          state_d = SERVE;
          delay_d = DLY;
          dir_d   = ~pend_q;
        end
      end
      OVER: begin
        if (start_rise) begin
          state_d = SERVE;
          crst_d  = 1'b1;
          delay_d = DLY;
          dir_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and registered (Moore) outputs
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= IDLE;
      delay_q  <= 8'd0;
      pend_q   <= 1'b0;
      start_q  <= 1'b0;
      EnL      <= 1'b0;
      EnR      <= 1'b0;
      CntRst   <= 1'b0;
      BallRun  <= 1'b0;
      ServeDir <= 1'b0;
      GameOver <= 1'b0;
      Winner   <= 1'b0;
    end else begin
      state_q  <= state_d;
      delay_q  <= delay_d;
      pend_q   <= pend_d;
      start_q  <= Start;
      EnL      <= (state_d == SCORE) & ~pend_d;
      EnR      <= (state_d == SCORE) & pend_d;
      CntRst   <= crst_d;
      BallRun  <= (state_d == PLAY);
      ServeDir <= dir_d;
      GameOver <= (state_d == OVER);
      Winner   <= win_d;
    end
  end

endmodule

// File: tb/tb_pong_score_ctrl.sv
// Directed bench for pong_score_ctrl with behavioural score counters.
// Instance a: WIN_SCORE=3, SERVE_DELAY=3; instance b: SERVE_DELAY=0.
module tb_pong_score_ctrl;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       a_tick = 0, a_start = 0, a_pl = 0, a_pr = 0;
  logic       b_tick = 0, b_start = 0, b_pl = 0, b_pr = 0;
  logic [7:0] a_sl, a_sr, b_sl, b_sr;
  logic       a_enl, a_enr, a_crst, a_run, a_dir, a_over, a_win;
  logic       b_enl, b_enr, b_crst, b_run, b_dir, b_over, b_win;
  logic [2:0] a_st, b_st;
  int         checks = 0;
  int         errors = 0;

  always #5 Clk = ~Clk;

  pong_score_ctrl #(.WIN_SCORE(3), .SERVE_DELAY(3)) dut_a (
    .Clk(Clk), .Rst(Rst), .FrameTick(a_tick), .Start(a_start),
    .PointL(a_pl), .PointR(a_pr), .ScoreL(a_sl), .ScoreR(a_sr),
    .EnL(a_enl), .EnR(a_enr), .CntRst(a_crst), .BallRun(a_run),
    .ServeDir(a_dir), .GameOver(a_over), .Winner(a_win), .State(a_st)
  );

  pong_score_ctrl #(.WIN_SCORE(11), .SERVE_DELAY(0)) dut_b (
    .Clk(Clk), .Rst(Rst), .FrameTick(b_tick), .Start(b_start),
    .PointL(b_pl), .PointR(b_pr), .ScoreL(b_sl), .ScoreR(b_sr),
    .EnL(b_enl), .EnR(b_enr), .CntRst(b_crst), .BallRun(b_run),
    .ServeDir(b_dir), .GameOver(b_over), .Winner(b_win), .State(b_st)
  );

  // score counter models (enable/reset counters)
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      a_sl <= 0; a_sr <= 0; b_sl <= 0; b_sr <= 0;
    end else begin
      if (a_crst) begin a_sl <= 0; a_sr <= 0; end
      else begin
        if (a_enl) a_sl <= a_sl + 8'd1;
        if (a_enr) a_sr <= a_sr + 8'd1;
      end
      if (b_crst) begin b_sl <= 0; b_sr <= 0; end
      else begin
        if (b_enl) b_sl <= b_sl + 8'd1;
        if (b_enr) b_sr <= b_sr + 8'd1;
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic a_serve_to_play();
    repeat (3) begin
      a_tick = 1; step(); a_tick = 0; step();
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({a_st, a_enl, a_enr, a_crst, a_run, a_dir, a_over, a_win} !== 10'd0) begin
      errors++;
      $display("FAIL reset_a got st=%0d outs=%b exp 0", a_st,
               {a_enl, a_enr, a_crst, a_run, a_dir, a_over, a_win});
    end
    checks++;
    if ({b_st, b_enl, b_enr, b_crst, b_run, b_dir, b_over, b_win} !== 10'd0) begin
      errors++;
      $display("FAIL reset_b got st=%0d exp 0", b_st);
    end
    #9 Rst = 1;
    step();
    checks++;
    if (a_st !== 3'd0) begin
      errors++; $display("FAIL idle_hold got %0d exp 0", a_st);
    end
  endtask

  task automatic test_start();
    a_start = 1; step(); a_start = 0;
    checks++;
    if (a_st !== 3'd1 || a_crst !== 1'b1 || a_dir !== 1'b1 || a_run !== 1'b0) begin
      errors++;
      $display("FAIL start_serve got st=%0d crst=%b dir=%b run=%b exp 1 1 1 0",
               a_st, a_crst, a_dir, a_run);
    end
    step();
    checks++;
    if (a_crst !== 1'b0 || a_st !== 3'd1) begin
      errors++; $display("FAIL crst_one_cycle got crst=%b st=%0d exp 0 1", a_crst, a_st);
    end
    for (int i = 1; i <= 3; i++) begin
      a_tick = 1; step(); a_tick = 0;
      checks++;
      if (a_run !== (i == 3)) begin
        errors++; $display("FAIL run_tick%0d got %b exp %b", i, a_run, i == 3);
      end
      step();
    end
    checks++;
    if (a_st !== 3'd2) begin
      errors++; $display("FAIL play_state got %0d exp 2", a_st);
    end
  endtask

  task automatic test_point_l();
    a_pl = 1; step(); a_pl = 0;
    checks++;
    if (a_st !== 3'd3 || a_enl !== 1'b1 || a_enr !== 1'b0 || a_run !== 1'b0) begin
      errors++;
      $display("FAIL pl_score got st=%0d enl=%b enr=%b run=%b exp 3 1 0 0",
               a_st, a_enl, a_enr, a_run);
    end
    a_pl = 1; step(); a_pl = 0;
    checks++;
    if (a_st !== 3'd4 || a_enl !== 1'b0 || a_sl !== 8'd1) begin
      errors++;
      $display("FAIL pl_check got st=%0d enl=%b sl=%0d exp 4 0 1", a_st, a_enl, a_sl);
    end
    step();
    checks++;
    if (a_st !== 3'd1 || a_dir !== 1'b1 || a_run !== 1'b0 || a_sl !== 8'd1) begin
      errors++;
      $display("FAIL pl_reserve got st=%0d dir=%b run=%b sl=%0d exp 1 1 0 1",
               a_st, a_dir, a_run, a_sl);
    end
    a_serve_to_play();
  endtask

  task automatic test_both();
    a_pl = 1; a_pr = 1; step(); a_pl = 0; a_pr = 0;
    checks++;
    if (a_enl !== 1'b1 || a_enr !== 1'b0) begin
      errors++; $display("FAIL both_en got enl=%b enr=%b exp 1 0", a_enl, a_enr);
    end
    step();
    checks++;
    if (a_sl !== 8'd2 || a_sr !== 8'd0) begin
      errors++; $display("FAIL both_scores got %0d/%0d exp 2/0", a_sl, a_sr);
    end
    step();
    checks++;
    if (a_st !== 3'd1) begin
      errors++; $display("FAIL both_serve got %0d exp 1", a_st);
    end
    a_serve_to_play();
  endtask

  task automatic test_win();
    for (int i = 1; i <= 3; i++) begin
      a_pr = 1; step(); a_pr = 0;
      checks++;
      if (a_enr !== 1'b1 || a_enl !== 1'b0) begin
        errors++; $display("FAIL win_en%0d got enr=%b enl=%b exp 1 0", i, a_enr, a_enl);
      end
      step(); step();
      if (i < 3) begin
        checks++;
        if (a_st !== 3'd1 || a_dir !== 1'b0 || a_sr !== 8'(i)) begin
          errors++;
          $display("FAIL win_serve%0d got st=%0d dir=%b sr=%0d exp 1 0 %0d",
                   i, a_st, a_dir, a_sr, i);
        end
        a_serve_to_play();
      end
    end
    checks++;
    if (a_st !== 3'd5 || a_over !== 1'b1 || a_win !== 1'b1 || a_run !== 1'b0) begin
      errors++;
      $display("FAIL win_over got st=%0d over=%b win=%b run=%b exp 5 1 1 0",
               a_st, a_over, a_win, a_run);
    end
    a_pl = 1; a_tick = 1; step(); step(); a_pl = 0; a_tick = 0;
    checks++;
    if (a_st !== 3'd5 || a_win !== 1'b1 || a_enl !== 1'b0) begin
      errors++; $display("FAIL over_hold got st=%0d win=%b enl=%b exp 5 1 0", a_st, a_win, a_enl);
    end
    a_start = 1; step(); a_start = 0;
    checks++;
    if (a_st !== 3'd1 || a_crst !== 1'b1 || a_over !== 1'b0 || a_dir !== 1'b1) begin
      errors++;
      $display("FAIL restart got st=%0d crst=%b over=%b dir=%b exp 1 1 0 1",
               a_st, a_crst, a_over, a_dir);
    end
    step();
    checks++;
    if (a_sl !== 8'd0 || a_sr !== 8'd0 || a_crst !== 1'b0) begin
      errors++;
      $display("FAIL restart_clr got %0d/%0d crst=%b exp 0/0 0", a_sl, a_sr, a_crst);
    end
  endtask

  task automatic test_rst_mid_score();
    a_serve_to_play();
    a_pl = 1; step(); a_pl = 0;
    checks++;
    if (a_enl !== 1'b1 || a_st !== 3'd3) begin
      errors++; $display("FAIL pre_rst got enl=%b st=%0d exp 1 3", a_enl, a_st);
    end
    #2 Rst = 0;
    #1;
    checks++;
    if (a_enl !== 1'b0 || a_enr !== 1'b0 || a_run !== 1'b0 || a_st !== 3'd0) begin
      errors++;
      $display("FAIL async_rst got enl=%b enr=%b run=%b st=%0d exp 0 0 0 0",
               a_enl, a_enr, a_run, a_st);
    end
    a_start = 1;
    #2 Rst = 1;
    step();
    checks++;
    if (a_st !== 3'd1 || a_crst !== 1'b1) begin
      errors++; $display("FAIL held_start got st=%0d crst=%b exp 1 1", a_st, a_crst);
    end
    step();
    checks++;
    if (a_st !== 3'd1 || a_crst !== 1'b0) begin
      errors++; $display("FAIL single_rise got st=%0d crst=%b exp 1 0", a_st, a_crst);
    end
    a_start = 0;
  endtask

  task automatic test_delay0();
    b_start = 1; step(); b_start = 0;
    checks++;
    if (b_st !== 3'd1 || b_crst !== 1'b1) begin
      errors++; $display("FAIL d0_serve got st=%0d crst=%b exp 1 1", b_st, b_crst);
    end
    b_pl = 1; step(); b_pl = 0;
    checks++;
    if (b_enl !== 1'b0 || b_st !== 3'd1) begin
      errors++; $display("FAIL d0_pl_ign got enl=%b st=%0d exp 0 1", b_enl, b_st);
    end
    b_pr = 1; step(); b_pr = 0;
    checks++;
    if (b_enr !== 1'b0 || b_st !== 3'd1 || b_run !== 1'b0) begin
      errors++; $display("FAIL d0_pr_ign got enr=%b st=%0d run=%b exp 0 1 0", b_enr, b_st, b_run);
    end
    b_tick = 1; step(); b_tick = 0;
    checks++;
    if (b_st !== 3'd2 || b_run !== 1'b1) begin
      errors++; $display("FAIL d0_play got st=%0d run=%b exp 2 1", b_st, b_run);
    end
    b_pr = 1; step(); b_pr = 0; step(); step();
    checks++;
    if (b_st !== 3'd1 || b_dir !== 1'b0 || b_sr !== 8'd1 || b_sl !== 8'd0) begin
      errors++;
      $display("FAIL d0_pr got st=%0d dir=%b sr=%0d sl=%0d exp 1 0 1 0",
               b_st, b_dir, b_sr, b_sl);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_point_l();
    test_both();
    test_win();
    test_rst_mid_score();
    test_delay0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
